lane_pixel_indexer: RTL and testbench

- Pipelined, parametrised pixel-to-palette-index generator for the rhythm-game VGA path.
- Takes a raster pixel stream; tracks x/y internally (no address divide).
- Per player: scrolling arrow lanes sourced from a frame-latched arrow array, plus a judgement indicator panel with a timed colour hold.
- Sits between the VGA timing block and the palette lookup; generalises the fixed 2-player, 4-arrow, combinational layout.

---
 rtl/lane_pixel_indexer_if.sv | 29 ++
 rtl/lane_pixel_indexer.sv | 233 +++++++++++++++++++++++
 tb/tb_lane_pixel_indexer.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/lane_pixel_indexer_if.sv
// Pixel stream, arrow/judgement inputs, sprite ROM port and palette index output
// of the lane pixel indexer, grouped so producer and consumer share one bundle.
interface lane_pixel_indexer_if #(
  parameter int NUM_PLAYERS = 2,
  parameter int ROWS        = 8,
  parameter int LANE_W_LOG2 = 6,
  parameter int ROW_H_LOG2  = 6
);
  logic                                pix_valid;
  logic                                pix_sof;
  logic [NUM_PLAYERS*ROWS*3-1:0]       arrow_array;
  logic [ROW_H_LOG2-1:0]               scroll;
  logic [NUM_PLAYERS-1:0]              judge_stb;
  logic [2*NUM_PLAYERS-1:0]            judge_code;
  logic [3+LANE_W_LOG2+ROW_H_LOG2-1:0] sprite_addr;
  logic [7:0]                          sprite_data;
  logic [7:0]                          index;
  logic                                index_valid;

  modport master (
    output pix_valid, pix_sof, arrow_array, scroll, judge_stb, judge_code, sprite_data,
    input  sprite_addr, index, index_valid
  );

  modport slave (
    input  pix_valid, pix_sof, arrow_array, scroll, judge_stb, judge_code, sprite_data,
    output sprite_addr, index, index_valid
  );
endinterface

// File: rtl/lane_pixel_indexer.sv
// Three-stage raster-to-palette-index pipeline: arrow lanes per player from a
// frame-latched arrow array, plus a bottom indicator panel with timed judgement colours.
module lane_pixel_indexer #(
  parameter int         H_ACTIVE        = 640,
  parameter int         V_ACTIVE        = 480,
  parameter int         PANEL_H         = 53,
  parameter int         NUM_PLAYERS     = 2,
  parameter int         LANES           = 5,
  parameter int         LANE_W_LOG2     = 6,
  parameter int         ROW_H_LOG2      = 6,
  parameter int         ROWS            = 8,
  parameter int         HOLD_FRAMES     = 30,
  parameter logic [7:0] BG_IDX          = 8'h00,
  parameter logic [7:0] TRANSPARENT_IDX = 8'hFF,
  parameter logic [7:0] DEFAULT_IDX     = 8'h10,
  parameter logic [7:0] EXC_IDX         = 8'h11,
  parameter logic [7:0] GOOD_IDX        = 8'h12,
  parameter logic [7:0] BAD_IDX         = 8'h13
) (
  input logic                  clock,
  input logic                  resetn,
  lane_pixel_indexer_if.slave  bus_io
);

  localparam int XW  = $clog2(H_ACTIVE);
  localparam int YW  = $clog2(V_ACTIVE);
  localparam int EW  = ((YW > ROW_H_LOG2) ? YW : ROW_H_LOG2) + 1;
  localparam int AW  = NUM_PLAYERS * ROWS * 3;
  localparam int SAW = 3 + LANE_W_LOG2 + ROW_H_LOG2;
  localparam int CW  = $clog2(HOLD_FRAMES + 1);

  typedef enum logic {IND_IDLE = 1'b0, IND_HOLD = 1'b1} ind_state_e;
  typedef enum logic [1:0] {RG_BG = 2'd0, RG_ARROW = 2'd1, RG_PANEL = 2'd2} region_e;

  function automatic logic [7:0] ind_colour(input ind_state_e st, input logic [1:0] code);
    logic [7:0] c;
    c = DEFAULT_IDX;
    if (st == IND_HOLD) begin
      case (code)
        2'b11:   c = EXC_IDX;
        2'b10:   c = GOOD_IDX;
        2'b01:   c = BAD_IDX;
        default: c = DEFAULT_IDX;
      endcase
    end else begin
      c = DEFAULT_IDX;
    end
    return c;
  endfunction

  logic [XW-1:0]  x_q, x_d, cur_x_s;
  logic [YW-1:0]  y_q, y_d, cur_y_s;
  logic [AW-1:0]  arr_q, arr_s;
  logic [ROW_H_LOG2-1:0] scroll_q, scroll_s;
  logic           sof_s;

  ind_state_e     ind_st_q   [NUM_PLAYERS];
  ind_state_e     ind_st_d   [NUM_PLAYERS];
  logic [1:0]     ind_code_q [NUM_PLAYERS];
  logic [1:0]     ind_code_d [NUM_PLAYERS];
  logic [CW-1:0]  ind_cnt_q  [NUM_PLAYERS];
  logic [CW-1:0]  ind_cnt_d  [NUM_PLAYERS];

  logic [XW-1:0]  lane_g_s, player_s, lane_s;
  logic [EW-1:0]  y_eff_s, row_s;
  logic [2:0]     code_s;
  logic [7:0]     panel_col_s;
  region_e        region_s;
  logic [SAW-1:0] addr_q, addr_d;

  logic           s1_valid_q, s2_valid_q;
  region_e        s1_region_q, s2_region_q;
  logic [7:0]     s1_col_q, s2_col_q;
  logic [7:0]     index_q, index_d;
  logic           index_valid_q;

  assign sof_s    = bus_io.pix_valid & bus_io.pix_sof;
  // The sof pixel already belongs to the new frame, so it sees the fresh inputs.
  assign arr_s    = sof_s ? bus_io.arrow_array : arr_q;
  assign scroll_s = sof_s ? bus_io.scroll : scroll_q;

  // Current pixel position and raster advance.
  always_comb begin
    if (sof_s) begin
      cur_x_s = '0;
      cur_y_s = '0;
    end else begin
      cur_x_s = x_q;
      cur_y_s = y_q;
    end
    x_d = x_q;
    y_d = y_q;
    if (bus_io.pix_valid) begin
      if (cur_x_s == XW'(H_ACTIVE - 1)) begin
        x_d = '0;
        y_d = (cur_y_s == YW'(V_ACTIVE - 1)) ? '0 : cur_y_s + YW'(1);
      end else begin
        x_d = cur_x_s + XW'(1);
        y_d = cur_y_s;
      end
    end else begin
      x_d = x_q;
      y_d = y_q;
    end
  end

  // Indicator FSM next state; a strobe beats a coincident sof.
  always_comb begin
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      ind_st_d[p]   = ind_st_q[p];
      ind_code_d[p] = ind_code_q[p];
      ind_cnt_d[p]  = ind_cnt_q[p];
      if (bus_io.judge_stb[p] && (bus_io.judge_code[2*p +: 2] != 2'b00)) begin
        ind_st_d[p]   = IND_HOLD;
        ind_code_d[p] = bus_io.judge_code[2*p +: 2];
        ind_cnt_d[p]  = CW'(HOLD_FRAMES);
      end else begin
        case (ind_st_q[p])
          IND_IDLE: ind_st_d[p] = IND_IDLE;
          IND_HOLD: begin
            if (sof_s) begin
              if (ind_cnt_q[p] <= CW'(1)) begin
                ind_st_d[p]   = IND_IDLE;
                ind_code_d[p] = 2'b00;
                ind_cnt_d[p]  = '0;
              end else begin
                ind_cnt_d[p]  = ind_cnt_q[p] - CW'(1);
              end
            end else begin
              ind_cnt_d[p] = ind_cnt_q[p];
            end
          end
          default: ind_st_d[p] = IND_IDLE;
        endcase
      end
    end
  end

  // Stage 1: region decode and sprite address.
  always_comb begin
    lane_g_s = cur_x_s >> LANE_W_LOG2;
    player_s = lane_g_s / XW'(LANES);
    lane_s   = lane_g_s - player_s * XW'(LANES);
    y_eff_s  = EW'(cur_y_s) + EW'(scroll_s);
    row_s    = y_eff_s >> ROW_H_LOG2;
    code_s   = 3'd0;
    panel_col_s = DEFAULT_IDX;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      panel_col_s = (player_s == XW'(p)) ? ind_colour(ind_st_q[p], ind_code_q[p]) : panel_col_s;
      for (int r = 0; r < ROWS; r++) begin
        code_s = ((player_s == XW'(p)) && (row_s == EW'(r))) ? arr_s[(p*ROWS+r)*3 +: 3] : code_s;
      end
    end
    if (player_s >= XW'(NUM_PLAYERS)) begin
      region_s = RG_BG;
    end else if (cur_y_s >= YW'(V_ACTIVE - PANEL_H)) begin
      region_s = RG_PANEL;
    end else if ((row_s < EW'(ROWS)) && (code_s != 3'd0) && (XW'(code_s) == lane_s + XW'(1))) begin
      region_s = RG_ARROW;
    end else begin
      region_s = RG_BG;
    end
    if (bus_io.pix_valid && (region_s == RG_ARROW)) begin
      addr_d = {code_s - 3'd1, y_eff_s[ROW_H_LOG2-1:0], cur_x_s[LANE_W_LOG2-1:0]};
    end else begin
      addr_d = addr_q;
    end
  end

  // Stage 3: resolve final palette index; hold it across bubbles.
  always_comb begin
    index_d = index_q;
    if (s2_valid_q) begin
      case (s2_region_q)
        RG_ARROW: index_d = (bus_io.sprite_data == TRANSPARENT_IDX) ? BG_IDX : bus_io.sprite_data;
        RG_PANEL: index_d = s2_col_q;
        default:  index_d = BG_IDX;
      endcase
    end else begin
      index_d = index_q;
    end
  end

  // Raster, snapshot, indicator and pipeline registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      x_q           <= '0;
      y_q           <= '0;
      arr_q         <= '0;
      scroll_q      <= '0;
      addr_q        <= '0;
      s1_valid_q    <= 1'b0;
      s1_region_q   <= RG_BG;
      s1_col_q      <= 8'h00;
      s2_valid_q    <= 1'b0;
      s2_region_q   <= RG_BG;
      s2_col_q      <= 8'h00;
      index_q       <= BG_IDX;
      index_valid_q <= 1'b0;
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        ind_st_q[p]   <= IND_IDLE;
        ind_code_q[p] <= 2'b00;
        ind_cnt_q[p]  <= '0;
      end
    end else begin
      x_q <= x_d;
      y_q <= y_d;
      if (sof_s) begin
        arr_q    <= bus_io.arrow_array;
        scroll_q <= bus_io.scroll;
      end
      addr_q        <= addr_d;
      s1_valid_q    <= bus_io.pix_valid;
      s1_region_q   <= region_s;
      s1_col_q      <= panel_col_s;
      s2_valid_q    <= s1_valid_q;
      s2_region_q   <= s1_region_q;
      s2_col_q      <= s1_col_q;
      index_q       <= index_d;
      index_valid_q <= s2_valid_q;
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        ind_st_q[p]   <= ind_st_d[p];
        ind_code_q[p] <= ind_code_d[p];
        ind_cnt_q[p]  <= ind_cnt_d[p];
      end
    end
  end

  assign bus_io.sprite_addr = addr_q;
  assign bus_io.index       = index_q;
  assign bus_io.index_valid = index_valid_q;

endmodule

// File: tb/tb_lane_pixel_indexer.sv
// Directed bench for lane_pixel_indexer using a short 640x6 frame so whole
// frames, panel colours and judgement holds fit a small cycle budget.
module tb_lane_pixel_indexer;
  localparam int H  = 640;
  localparam int V  = 6;
  localparam int PH = 2;
  localparam logic [7:0] BG = 8'h00, DEF = 8'h10, EXC = 8'h11, GOOD = 8'h12, BAD = 8'h13;

  logic clock = 1'b0;
  logic resetn;
  logic rom_clear = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  int   tx = 0;
  int   ty = 0;
  bit   hv [3];
  bit   hc [3];
  logic [7:0] he [3];
  logic [7:0] col0 = DEF;
  logic [7:0] col1 = DEF;
  logic [47:0] arr_v;
  string tag = "init";

  lane_pixel_indexer_if #(.NUM_PLAYERS(2), .ROWS(8), .LANE_W_LOG2(6), .ROW_H_LOG2(6)) bus ();

  lane_pixel_indexer #(
    .H_ACTIVE(H), .V_ACTIVE(V), .PANEL_H(PH), .NUM_PLAYERS(2), .LANES(5),
    .LANE_W_LOG2(6), .ROW_H_LOG2(6), .ROWS(8), .HOLD_FRAMES(2)
  ) dut (
    .clock (clock),
    .resetn(resetn),
    .bus_io(bus)
  );

  always #5 clock = ~clock;

  // Synchronous sprite ROM: data is the low address byte unless forced clear.
  always @(posedge clock) bus.sprite_data <= rom_clear ? 8'hFF : bus.sprite_addr[7:0];

  function automatic logic [7:0] panel_exp(input int x, input int y);
    if (y >= V - PH) return (x < 320) ? col0 : col1;
    return BG;
  endfunction

  task automatic clear_hist();
    for (int i = 0; i < 3; i++) begin
      hv[i] = 1'b0;
      hc[i] = 1'b0;
      he[i] = 8'h00;
    end
  endtask

  task automatic step(input bit v, input bit sof, input bit chk, input bit use_model,
                      input logic [7:0] exp_in);
    logic [7:0] e;
    if (v && sof) begin
      tx = 0;
      ty = 0;
    end
    e = use_model ? panel_exp(tx, ty) : exp_in;
    bus.pix_valid = v;
    bus.pix_sof   = sof;
    @(posedge clock);
    #1;
    bus.pix_valid = 1'b0;
    bus.pix_sof   = 1'b0;
    if (v) begin
      tx++;
      if (tx == H) begin
        tx = 0;
        ty++;
        if (ty == V) ty = 0;
      end
    end
    hv[2] = hv[1]; hv[1] = hv[0]; hv[0] = v;
    hc[2] = hc[1]; hc[1] = hc[0]; hc[0] = v & chk;
    he[2] = he[1]; he[1] = he[0]; he[0] = e;
    n_vec++;
    assert (bus.index_valid === hv[2]) else begin
      n_err++;
      $error("FAIL %s index_valid: got %b want %b", tag, bus.index_valid, hv[2]);
    end
    if (hc[2]) begin
      n_vec++;
      assert (bus.index === he[2]) else begin
        n_err++;
        $error("FAIL %s index: got %h want %h", tag, bus.index, he[2]);
      end
    end
  endtask

  task automatic stream(input int n, input bit sof_first, input bit chk);
    for (int i = 0; i < n; i++) step(1'b1, sof_first && (i == 0), chk, 1'b1, 8'h00);
  endtask

  task automatic check_addr(input logic [14:0] exp);
    n_vec++;
    assert (bus.sprite_addr === exp) else begin
      n_err++;
      $error("FAIL %s sprite_addr: got %h want %h", tag, bus.sprite_addr, exp);
    end
  endtask

  task automatic check_reset_outputs();
    n_vec++;
    assert (bus.index === BG) else begin
      n_err++;
      $error("FAIL %s reset index: got %h want %h", tag, bus.index, BG);
    end
    n_vec++;
    assert (bus.index_valid === 1'b0) else begin
      n_err++;
      $error("FAIL %s reset index_valid: got %b want 0", tag, bus.index_valid);
    end
    check_addr(15'h0000);
  endtask

  initial begin
    resetn          = 1'b0;
    bus.pix_valid   = 1'b0;
    bus.pix_sof     = 1'b0;
    bus.arrow_array = '0;
    bus.scroll      = '0;
    bus.judge_stb   = '0;
    bus.judge_code  = '0;
    clear_hist();

    tag = "reset";
    repeat (3) @(posedge clock);
    #1;
    check_reset_outputs();
    resetn = 1'b1;

    // Plain frame, then two more lines without sof to exercise x/y wrap.
    tag = "blank_frame";
    stream(H * V + 2 * H, 1'b1, 1'b1);

    // Judgement hold: excellent for the strobe frame plus one more.
    tag = "judge_exc";
    stream(10, 1'b1, 1'b1);
    bus.judge_stb = 2'b01; bus.judge_code = 4'b0011;
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    bus.judge_stb = 2'b00; bus.judge_code = 4'b0000;
    col0 = EXC;
    stream(H * V - 10, 1'b0, 1'b1);
    stream(H * V, 1'b1, 1'b1);
    tag = "judge_expire";
    col0 = DEF;
    stream(H * V, 1'b1, 1'b1);

    tag = "judge_bad";
    stream(10, 1'b1, 1'b1);
    bus.judge_stb = 2'b01; bus.judge_code = 4'b0001;
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    bus.judge_stb = 2'b00; bus.judge_code = 4'b0000;
    col0 = BAD;
    stream(H * V - 10, 1'b0, 1'b1);

    // Strobe coincident with sof reloads the count instead of decrementing.
    tag = "judge_sof_reload";
    bus.judge_stb = 2'b01; bus.judge_code = 4'b0010;
    stream(1, 1'b1, 1'b1);
    bus.judge_stb = 2'b00; bus.judge_code = 4'b0000;
    col0 = GOOD;
    stream(H * V - 1, 1'b0, 1'b1);
    tag = "judge_zero_ignored";
    stream(10, 1'b1, 1'b1);
    bus.judge_stb = 2'b11; bus.judge_code = 4'b0000;
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    bus.judge_stb = 2'b00;
    stream(H * V - 10, 1'b0, 1'b1);
    tag = "judge_good_expire";
    col0 = DEF;
    stream(H * V, 1'b1, 1'b1);

    // Arrow in player0 row0 lane1; inputs change mid-frame but the snapshot holds.
    tag = "arrow_p0";
    arr_v = '0; arr_v[2:0] = 3'd2;
    bus.arrow_array = arr_v; bus.scroll = 6'd0;
    stream(1, 1'b1, 1'b0);
    bus.arrow_array = '0; bus.scroll = 6'd63;
    stream(H + 4, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, BG);
    stream(64, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 8'h46);
    check_addr({3'd1, 6'd1, 6'd6});
    stream(3, 1'b0, 1'b0);

    tag = "arrow_next_frame";
    stream(H + 70, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, BG);
    stream(3, 1'b0, 1'b0);

    // Player1 row1 bolt with scroll 63; bubbles before the target must not move x.
    tag = "arrow_p1_scroll";
    arr_v = '0; arr_v[29:27] = 3'd5;
    bus.arrow_array = arr_v; bus.scroll = 6'd63;
    stream(H + 600, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 1'b1, 1'b0, 8'h18);
    check_addr({3'd4, 6'd0, 6'd24});
    stream(3, 1'b0, 1'b0);

    tag = "reset_mid_frame";
    resetn = 1'b0;
    #1;
    check_reset_outputs();
    @(posedge clock);
    #1;
    resetn = 1'b1;
    clear_hist();
    tx = 0; ty = 0;
    tag = "after_reset_no_sof";
    stream(H + 601, 1'b0, 1'b1);

    tag = "arrow_transparent";
    rom_clear = 1'b1;
    stream(H + 600, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, BG);
    check_addr({3'd4, 6'd0, 6'd24});
    stream(3, 1'b0, 1'b0);
    tag = "flush";
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
